// File: rtl/rx78_pixel_fetch.sv
// rx78_pixel_fetch: fetches three VRAM bit-planes per 8-pixel group one group ahead of the
// beam and serialises them into 3-bit colour indices aligned with the delayed blank/sync.
module rx78_pixel_fetch #(
  parameter int HSTART = 32,
  parameter int VSTART = 20,
  parameter int HACT   = 192,
  parameter int VACT   = 184
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  hcount,
  input  logic [8:0]  vcount,
  input  logic        hb_in,
  input  logic        vb_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        page,
  input  logic [2:0]  border,
  output logic [15:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_dout,
  output logic [2:0]  pix,
  output logic        active,
  output logic        hb,
  output logic        vb,
  output logic        hs,
  output logic        vs
);

  typedef enum logic [2:0] {IDLE = 3'd0, RD0 = 3'd1, RD1 = 3'd2, RD2 = 3'd3, CAP = 3'd4} state_t;

  localparam logic [9:0] H_FETCH0    = 10'(HSTART - 8);
  localparam logic [9:0] H_FETCH_END = 10'(HSTART + HACT - 8);
  localparam logic [9:0] H_ACT0      = 10'(HSTART);
  localparam logic [9:0] H_ACT_END   = 10'(HSTART + HACT);
  localparam logic [9:0] V_ACT0      = 10'(VSTART);
  localparam logic [9:0] V_ACT_END   = 10'(VSTART + VACT);

  state_t      state, state_next;
  logic [9:0]  h_ext, v_ext, fetch_rel, row;
  logic [12:0] row_ext, offset, offset_hold;
  logic [2:0]  col_bit;
  logic        line_act, fetch_slot, fetch_go, col_act, load;
  logic        armed, page_hold;
  logic [7:0]  lat0, lat1, lat2, sr0, sr1, sr2, cur0, cur1, cur2;
  logic        rd_next, cap0, cap1, cap2;
  logic [15:0] addr_next;

  assign h_ext      = {1'b0, hcount};
  assign v_ext      = {1'b0, vcount};
  assign line_act   = (v_ext >= V_ACT0) && (v_ext < V_ACT_END);
  assign fetch_rel  = h_ext - H_FETCH0;
  assign fetch_slot = line_act && (h_ext >= H_FETCH0) && (h_ext < H_FETCH_END)
                      && (fetch_rel[2:0] == 3'd0);
  // After a reset, fetching only resumes at the first group of an active line.
  assign fetch_go   = fetch_slot && (armed || (h_ext == H_FETCH0)) && (state == IDLE);
  assign row        = v_ext - V_ACT0;
  assign row_ext    = {3'd0, row};
  assign offset     = (row_ext << 4) + (row_ext << 3) + {6'd0, fetch_rel[9:3]};
  assign col_act    = line_act && (h_ext >= H_ACT0) && (h_ext < H_ACT_END);
  assign col_bit    = h_ext[2:0] - H_ACT0[2:0];
  assign load       = col_act && (col_bit == 3'd0);
  assign cur0       = load ? lat0 : {1'b0, sr0[7:1]};
  assign cur1       = load ? lat1 : {1'b0, sr1[7:1]};
  assign cur2       = load ? lat2 : {1'b0, sr2[7:1]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fetch_go) state_next = RD0;
        else          state_next = IDLE;
      end
      RD0:     state_next = RD1;
      RD1:     state_next = RD2;
      RD2:     state_next = CAP;
      CAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data trails the strobe by one cycle, so each plane is captured two states later.
  always_comb begin
    rd_next   = 1'b0;
    addr_next = vram_addr;
    cap0      = 1'b0;
    cap1      = 1'b0;
    cap2      = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_go) begin
          rd_next   = 1'b1;
          addr_next = {page, 2'd0, offset};
        end else begin
          rd_next   = 1'b0;
        end
      end
      RD0: begin
        rd_next   = 1'b1;
        addr_next = {page_hold, 2'd1, offset_hold};
      end
      RD1: begin
        rd_next   = 1'b1;
        addr_next = {page_hold, 2'd2, offset_hold};
        cap0      = 1'b1;
      end
      RD2:     cap1 = 1'b1;
      CAP:     cap2 = 1'b1;
      default: rd_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr   <= 16'd0;
      vram_rd     <= 1'b0;
      armed       <= 1'b0;
      page_hold   <= 1'b0;
      offset_hold <= 13'd0;
      lat0 <= 8'd0; lat1 <= 8'd0; lat2 <= 8'd0;
      sr0  <= 8'd0; sr1  <= 8'd0; sr2  <= 8'd0;
      pix    <= 3'd0;
      active <= 1'b0;
      hb <= 1'b1; vb <= 1'b1; hs <= 1'b1; vs <= 1'b1;
    end else begin
      vram_addr <= addr_next;
      vram_rd   <= rd_next;
      if (fetch_go) begin
        armed       <= 1'b1;
        page_hold   <= page;
        offset_hold <= offset;
      end
      if (cap0) lat0 <= vram_dout;
      if (cap1) lat1 <= vram_dout;
      if (cap2) lat2 <= vram_dout;
      if (col_act) begin
        sr0 <= cur0;
        sr1 <= cur1;
        sr2 <= cur2;
      end
      if (col_act && armed) begin
        pix    <= {cur2[0], cur1[0], cur0[0]};
        active <= 1'b1;
      end else begin
        pix    <= border;
        active <= 1'b0;
      end
      hb <= hb_in; vb <= vb_in; hs <= hs_in; vs <= vs_in;
    end
  end

endmodule

// File: tb/tb_rx78_pixel_fetch.sv
// tb_rx78_pixel_fetch: drives raster lines directly, models the VRAM, and checks
// fetch strobes/addresses, serialised pixels and delayed sync against hand-derived values.
module tb_rx78_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  hcount = 9'd0, vcount = 9'd0;
  logic        hb_in = 1'b0, vb_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic        page = 1'b0;
  logic [2:0]  border = 3'd0;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_dout = 8'd0;
  logic [2:0]  pix;
  logic        active, hb, vb, hs, vs;

  logic [7:0] mem [65536];
  int n_vec = 0;
  int n_err = 0;
  int cur_h = 0;
  int cur_v = 0;
  int cnt;

  rx78_pixel_fetch dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .hb_in(hb_in), .vb_in(vb_in), .hs_in(hs_in), .vs_in(vs_in),
    .page(page), .border(border),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_dout(vram_dout),
    .pix(pix), .active(active), .hb(hb), .vb(vb), .hs(hs), .vs(vs)
  );

  always #5 clk = ~clk;

  // VRAM model: data one cycle after the strobe
  always @(posedge clk) if (vram_rd) vram_dout <= mem[vram_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s v=%0d h=%0d got=%0h expected=%0h", tag, cur_v, cur_h, got, exp);
    end
  endtask

  // One full raster line; pg_h >= 0 raises page from that hcount, rst_h >= 0 pulses reset there.
  task automatic run_line(input int v, input logic [2:0] bdr, input int pg_h, input int rst_h,
                          output int rd_cnt);
    logic pgk [24];
    logic ok, lineact, exp_rd;
    logic [3:0] exp_sync;
    logic [7:0] m0, m1, m2;
    int k, b, off, a;
    rd_cnt  = 0;
    ok      = 1'b1;
    lineact = (v >= 20) && (v < 204);
    for (int i = 0; i < 24; i++) pgk[i] = 1'b0;
    for (int h = 0; h < 342; h++) begin
      cur_h = h; cur_v = v;
      hcount = 9'(h); vcount = 9'(v); border = bdr;
      page   = (pg_h >= 0) && (h >= pg_h);
      reset  = (h == rst_h);
      hb_in = (h >= 256); vb_in = (v >= 250); hs_in = (h >= 280) && (h < 300); vs_in = (v == 260);
      exp_sync = {hb_in, vb_in, hs_in, vs_in};
      if (lineact && h >= 24 && h <= 208 && ((h - 24) % 8) == 0) pgk[(h - 24) / 8] = page;
      @(posedge clk); #1;
      if (h == rst_h) begin
        ok = 1'b0;
        check_val("rst_rd", {31'd0, vram_rd}, 32'd0);
        check_val("rst_addr", {16'd0, vram_addr}, 32'd0);
        check_val("rst_pix", {28'd0, active, pix}, 32'd0);
        check_val("rst_sync", {28'd0, hb, vb, hs, vs}, 32'hF);
      end else begin
        exp_rd = ok && lineact && (h >= 24) && (h < 211) && (((h - 24) % 8) < 3);
        check_val("rd", {31'd0, vram_rd}, {31'd0, exp_rd});
        if (vram_rd) rd_cnt++;
        if (exp_rd) begin
          k = (h - 24) / 8;
          a = (pgk[k] ? 32768 : 0) + ((h - 24) % 8) * 8192 + (v - 20) * 24 + k;
          check_val("addr", {16'd0, vram_addr}, a);
        end
        if (ok && lineact && h >= 32 && h < 224) begin
          k = (h - 32) / 8; b = (h - 32) % 8;
          off = (v - 20) * 24 + k + (pgk[k] ? 32768 : 0);
          m0 = mem[off]; m1 = mem[off + 8192]; m2 = mem[off + 16384];
          check_val("pix", {28'd0, active, pix}, {28'd0, 1'b1, m2[b], m1[b], m0[b]});
        end else begin
          check_val("border", {28'd0, active, pix}, {28'd0, 1'b0, bdr});
        end
        check_val("sync", {28'd0, hb, vb, hs, vs}, {28'd0, exp_sync});
        // hand-computed spot vectors
        if (v == 20 && h >= 24 && h <= 26)
          check_val("first_addr", {16'd0, vram_addr},
                    (h == 24) ? 32'h0000 : ((h == 25) ? 32'h2000 : 32'h4000));
        if (v == 20 && h >= 32 && h < 40)
          check_val("first_pix", {29'd0, pix}, (h == 32) ? 32'd1 : 32'd0);
        if (v == 21 && h >= 32 && h < 40)
          check_val("aa_cc_f0", {29'd0, pix}, 32'(h - 32));
        if (v == 203 && h == 208)
          check_val("last_off", {16'd0, vram_addr}, 32'h113F);
        if (v == 22 && (h == 96 || h == 104))
          check_val("page_bit", {31'd0, vram_addr[15]}, (h == 104) ? 32'd1 : 32'd0);
      end
    end
    reset = 1'b0;
    page  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + (i >> 8) * 11 + 5);
    mem[16'h0000] = 8'h01; mem[16'h2000] = 8'h00; mem[16'h4000] = 8'h00;
    mem[16'h0018] = 8'hAA; mem[16'h2018] = 8'hCC; mem[16'h4018] = 8'hF0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_rd", {31'd0, vram_rd}, 32'd0);
    check_val("reset_addr", {16'd0, vram_addr}, 32'd0);
    check_val("reset_pix", {28'd0, active, pix}, 32'd0);
    check_val("reset_sync", {28'd0, hb, vb, hs, vs}, 32'hF);
    reset = 1'b0;

    run_line(19, 3'd2, -1, -1, cnt);  check_val("cnt19", cnt, 32'd0);
    run_line(20, 3'd5, -1, -1, cnt);  check_val("cnt20", cnt, 32'd72);
    run_line(21, 3'd1, -1, -1, cnt);  check_val("cnt21", cnt, 32'd72);
    run_line(22, 3'd4, 100, -1, cnt); check_val("cnt22", cnt, 32'd72);
    run_line(23, 3'd6, -1, 25, cnt);
    run_line(24, 3'd0, -1, -1, cnt);  check_val("cnt24", cnt, 32'd72);
    run_line(203, 3'd7, -1, -1, cnt); check_val("cnt203", cnt, 32'd72);
    run_line(204, 3'd5, -1, -1, cnt); check_val("cnt204", cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
